hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised, scoreboard-based issue hazard unit for the multi-issue in-order pipeline; the next generation of the ID-stage hazard detection block. A per-register countdown scoreboard tracks in-flight producers of configurable latency, and each cycle the block decides how many instructions of the IF/ID bundle may issue in order. It drives PC write, IF/ID write and control-bubble select, and supports partial-bundle issue, branch-in-ID penalty, back-end hold and flush.

## Interface
- NREG, 8: architectural registers; AW = $clog2(NREG)
- ISSUE_W, 2: slots per IF/ID bundle
- NSRC, 3: source fields per slot (Rm, Rn, Rd-as-source)
- ALU_LAT, 1: scoreboard load value for non-load producers
- LOAD_LAT, 2: scoreboard load value for load producers
- BR_PEN, 1: extra cycles a branch (resolved in ID) waits vs. an EX consumer
- ZERO_REG, 0: 1 = register 0 never tracked, never hazards
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- slot_vld  in  ISSUE_W  slot i holds a valid instruction
- src_addr  in  ISSUE_W*NSRC*AW  slot i, field k at index (i*NSRC+k)*AW
- src_vld  in  ISSUE_W*NSRC  source field actually read
- dst_addr  in  ISSUE_W*AW  destination register
- dst_vld  in  ISSUE_W  slot writes a register
- is_load  in  ISSUE_W  producer is a load
- is_branch  in  ISSUE_W  slot is a branch (reads sources in ID)
- ex_hold  in  1  back end stalled: freeze scoreboard, issue nothing
- flush  in  1  redirect: issue nothing this cycle
- issue_cnt  out  $clog2(ISSUE_W+1)  number of leading slots issuing
- pc_write  out  1  all valid slots issue
- if_id_write  out  1  equals pc_write
- ctrl_bubble  out  1  issue_cnt==0 and slot_vld[0]: inject NOP into ID/EX
- busy  out  NREG  bit r = cnt[r]!=0 (debug)

## Operation
- State: cnt[r], width $clog2(max(ALU_LAT,LOAD_LAT)+1), one per register; cycles until the value reaches ID.
- Source hazard, slot i field k (src_vld set, r = address, not r==0 with ZERO_REG=1): non-branch stalls when cnt[r] > BR_PEN; branch stalls when cnt[r] != 0.
- Intra-bundle hazard: slot j has a valid source equal to a valid dst_addr of any slot i<j; it is always treated as a hazard (no same-cycle forwarding inside a bundle).
- Slot blocked = source hazard, intra-bundle hazard or !slot_vld. issue_cnt = index of first blocked slot (ISSUE_W if none), in-order, no skipping.
- rst, flush or ex_hold force issue_cnt=0.
- pc_write = if_id_write = (issue_cnt == number of leading valid slots); a partial issue deasserts both, and the fetch buffer shifts by issue_cnt.
- Scoreboard update per clock, unless ex_hold: every cnt decrements, saturating at 0. Each issued slot with dst_vld loads its target with L = is_load ? LOAD_LAT : ALU_LAT, taking max(L, decremented cnt). Among same-bundle writers of one register the largest value wins. Issue load overrides decrement.
- ex_hold: all cnt held, no loads.
- rst: all cnt cleared next edge; takes priority over everything.

## Timing
- Outputs are combinational from inputs and cnt; the scoreboard is registered and updates on the rising edge.
- Reset values (during rst and the cycle after with idle inputs): issue_cnt=0 during rst, busy=0 after, ctrl_bubble = slot_vld[0], pc_write=if_id_write=0 during rst.
- Stall counts with defaults, consumer in the cycle after producer issue:
  - ALU→ALU: 0
  - ALU→branch: 1
  - load→ALU: 1
  - load→branch: 2
- ex_hold for N cycles extends pending stalls by exactly N.
- Reset mid-stall: the next cycle issues freely.

## Test plan
- Reset: rst 2 cycles, then two valid independent slots → busy=0, issue_cnt=2, pc_write=1, ctrl_bubble=0.
- Load r3 issued cycle 0 in slot0; cycle 1 slot0 ADD reads r3 → issue_cnt=0, ctrl_bubble=1, pc_write=0; cycle 2 → issue_cnt≥1. Repeat with a branch reading r3: 2 bubble cycles.
- ALU writes r5 cycle 0; cycle 1 branch reads r5 → 1 bubble; ALU reader of r5 → no bubble.
- Bundle: slot0 writes r2, slot1 reads r2 → issue_cnt=1, pc_write=if_id_write=0, ctrl_bubble=0, busy[2]=1 next cycle.
- Load r4 issued, ex_hold high 3 cycles → busy[4] stays 1 and cnt[4] stays 2 throughout. After release, an ALU reader of r4 stalls 1 more cycle. Flush high → issue_cnt=0 regardless of hazards.
- ZERO_REG=1: load to r0, then reader of r0 → no stall, busy[0]=0. Same-bundle double write of r6 (ALU slot0, load slot1) → r6 reader stalls 1 cycle.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// IF/ID bundle view into the issue hazard unit: slot
// descriptors in, issue decision and scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int NREG    = 8,
    parameter int ISSUE_W = 2,
    parameter int NSRC    = 3
);
    localparam int AW = $clog2(NREG);
    localparam int IW = $clog2(ISSUE_W + 1);

    logic [ISSUE_W-1:0]         slot_vld;
    logic [ISSUE_W*NSRC*AW-1:0] src_addr;
    logic [ISSUE_W*NSRC-1:0]    src_vld;
    logic [ISSUE_W*AW-1:0]      dst_addr;
    logic [ISSUE_W-1:0]         dst_vld;
    logic [ISSUE_W-1:0]         is_load;
    logic [ISSUE_W-1:0]         is_branch;
    logic                       ex_hold;
    logic                       flush;
    logic [IW-1:0]              issue_cnt;
    logic                       pc_write;
    logic                       if_id_write;
    logic                       ctrl_bubble;
    logic [NREG-1:0]            busy;

    modport master (
        output slot_vld, src_addr, src_vld,
        output dst_addr, dst_vld, is_load, is_branch,
        output ex_hold, flush,
        input  issue_cnt, pc_write, if_id_write,
        input  ctrl_bubble, busy
    );

    modport slave (
        input  slot_vld, src_addr, src_vld,
        input  dst_addr, dst_vld, is_load, is_branch,
        input  ex_hold, flush,
        output issue_cnt, pc_write, if_id_write,
        output ctrl_bubble, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard issue hazard unit: decides how many
// leading IF/ID slots issue in order and tracks producers.
module hazard_scoreboard #(
    parameter int NREG     = 8,
    parameter int ISSUE_W  = 2,
    parameter int NSRC     = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int BR_PEN   = 1,
    parameter int ZERO_REG = 0
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave hz
);
    localparam int AW   = $clog2(NREG);
    localparam int IW   = $clog2(ISSUE_W + 1);
    localparam int MAXL = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int CW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);
    localparam logic [CW-1:0] L_ALU = CW'(ALU_LAT);
    localparam logic [CW-1:0] L_LD  = CW'(LOAD_LAT);

    logic [CW-1:0] r_cnt [NREG];
    logic [CW-1:0] w_nxt [NREG];
    logic [AW-1:0] w_src [ISSUE_W][NSRC];
    logic [AW-1:0] w_dst [ISSUE_W];
    logic [CW-1:0] w_lat [ISSUE_W];
    logic [ISSUE_W-1:0] w_blk;
    logic [IW-1:0] w_issue;
    logic [IW-1:0] w_lead;
    logic [NREG-1:0] w_busy;

    function automatic logic f_trk(input logic [AW-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            w_dst[i] = hz.dst_addr[i*AW +: AW];
            w_lat[i] = hz.is_load[i] ? L_LD : L_ALU;
            for (int k = 0; k < NSRC; k++)
                w_src[i][k] = hz.src_addr[(i*NSRC+k)*AW +: AW];
        end
    end

    // Branches read operands in ID, so they wait BR_PEN cycles longer.
    always_comb begin
        w_blk = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_blk[i] = !hz.slot_vld[i];
            for (int k = 0; k < NSRC; k++) begin
                if (hz.src_vld[i*NSRC+k] && f_trk(w_src[i][k])) begin
                    if (hz.is_branch[i]) begin
                        if (r_cnt[w_src[i][k]] != '0)
                            w_blk[i] = 1'b1;
                    end else if (int'(r_cnt[w_src[i][k]]) > BR_PEN) begin
                        w_blk[i] = 1'b1;
                    end
                    for (int j = 0; j < i; j++)
                        if (hz.dst_vld[j] && w_dst[j] == w_src[i][k])
                            w_blk[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic stop;
        logic lstop;
        w_issue = '0;
        w_lead  = '0;
        stop    = 1'b0;
        lstop   = 1'b0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (w_blk[i])
                stop = 1'b1;
            if (!stop)
                w_issue = w_issue + IW'(1);
            if (!hz.slot_vld[i])
                lstop = 1'b1;
            if (!lstop)
                w_lead = w_lead + IW'(1);
        end
        if (rst || hz.ex_hold || hz.flush)
            w_issue = '0;
    end

    // Largest of decremented count and every same-bundle load wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - CW'(1) : '0;
            for (int i = 0; i < ISSUE_W; i++) begin
                if ((IW'(i) < w_issue) && hz.dst_vld[i] &&
                    (w_dst[i] == AW'(r)) && f_trk(w_dst[i]) &&
                    (w_lat[i] > w_nxt[r]))
                    w_nxt[r] = w_lat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= '0;
        end else if (!hz.ex_hold) begin
            for (int r = 0; r < NREG; r++)
                r_cnt[r] <= w_nxt[r];
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++)
            w_busy[r] = (r_cnt[r] != '0);
    end

    assign hz.issue_cnt   = w_issue;
    assign hz.pc_write    = !rst && (w_issue == w_lead);
    assign hz.if_id_write = !rst && (w_issue == w_lead);
    assign hz.ctrl_bubble = (w_issue == '0) && hz.slot_vld[0];
    assign hz.busy        = w_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed check of hazard_scoreboard against a
// ready-time model; one instance tracks r0, the other does not.
module tb_hazard_scoreboard;
    localparam int NREG     = 8;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int BR_PEN   = 1;

    logic clk;
    logic rst;
    logic [1:0]  slot_vld;
    logic [17:0] src_addr;
    logic [5:0]  src_vld;
    logic [5:0]  dst_addr;
    logic [1:0]  dst_vld;
    logic [1:0]  is_load;
    logic [1:0]  is_branch;
    logic        ex_hold;
    logic        flush;

    int n_vec;
    int n_bad;
    int act;
    int rdy [2][NREG];
    int nx  [2];

    hazard_scoreboard_if #(.NREG(8), .ISSUE_W(2), .NSRC(3)) hz0 ();
    hazard_scoreboard_if #(.NREG(8), .ISSUE_W(2), .NSRC(3)) hz1 ();

    assign hz0.slot_vld  = slot_vld;
    assign hz0.src_addr  = src_addr;
    assign hz0.src_vld   = src_vld;
    assign hz0.dst_addr  = dst_addr;
    assign hz0.dst_vld   = dst_vld;
    assign hz0.is_load   = is_load;
    assign hz0.is_branch = is_branch;
    assign hz0.ex_hold   = ex_hold;
    assign hz0.flush     = flush;
    assign hz1.slot_vld  = slot_vld;
    assign hz1.src_addr  = src_addr;
    assign hz1.src_vld   = src_vld;
    assign hz1.dst_addr  = dst_addr;
    assign hz1.dst_vld   = dst_vld;
    assign hz1.is_load   = is_load;
    assign hz1.is_branch = is_branch;
    assign hz1.ex_hold   = ex_hold;
    assign hz1.flush     = flush;

    hazard_scoreboard #(.ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .hz(hz0.slave)
    );
    hazard_scoreboard #(.ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .hz(hz1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Model: each register holds the absolute active-cycle count at
    // which its value is readable; holds do not advance that clock.
    function automatic int rem(input int z, input int r);
        int d;
        d = rdy[z][r] - act;
        return (d > 0) ? d : 0;
    endfunction

    function automatic bit trk(input int z, input int r);
        return !(z == 1 && r == 0);
    endfunction

    function automatic int sa(input int i, input int k);
        return int'(src_addr[(i*3+k)*3 +: 3]);
    endfunction

    function automatic int da(input int i);
        return int'(dst_addr[i*3 +: 3]);
    endfunction

    function automatic int exp_issue(input int z);
        int n;
        n = 0;
        if (rst || ex_hold || flush)
            return 0;
        for (int i = 0; i < 2; i++) begin
            bit blk;
            blk = !slot_vld[i];
            for (int k = 0; k < 3; k++) begin
                if (src_vld[i*3+k] && trk(z, sa(i, k))) begin
                    if (is_branch[i] && rem(z, sa(i, k)) > 0)
                        blk = 1'b1;
                    if (!is_branch[i] && rem(z, sa(i, k)) > BR_PEN)
                        blk = 1'b1;
                    for (int j = 0; j < i; j++)
                        if (dst_vld[j] && da(j) == sa(i, k))
                            blk = 1'b1;
                end
            end
            if (blk)
                return n;
            n++;
        end
        return n;
    endfunction

    task automatic cmp(input int z, input int ic, input int pw,
                       input int iw, input int cb,
                       input logic [7:0] bz);
        int n;
        int lead;
        logic [7:0] eb;
        n = exp_issue(z);
        nx[z] = n;
        lead = !slot_vld[0] ? 0 : (!slot_vld[1] ? 1 : 2);
        check($sformatf("d%0d issue_cnt", z), ic, n);
        check($sformatf("d%0d pc_write", z), pw,
              int'(!rst && n == lead));
        check($sformatf("d%0d if_id_write", z), iw,
              int'(!rst && n == lead));
        check($sformatf("d%0d ctrl_bubble", z), cb,
              int'(n == 0 && slot_vld[0]));
        if (!rst) begin
            for (int r = 0; r < NREG; r++)
                eb[r] = (rem(z, r) != 0);
            check($sformatf("d%0d busy", z), int'(bz), int'(eb));
        end
    endtask

    task automatic look();
        @(negedge clk);
        cmp(0, int'(hz0.issue_cnt), int'(hz0.pc_write),
            int'(hz0.if_id_write), int'(hz0.ctrl_bubble), hz0.busy);
        cmp(1, int'(hz1.issue_cnt), int'(hz1.pc_write),
            int'(hz1.if_id_write), int'(hz1.ctrl_bubble), hz1.busy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            act++;
            for (int z = 0; z < 2; z++)
                for (int r = 0; r < NREG; r++)
                    rdy[z][r] = act;
        end else if (!ex_hold) begin
            for (int z = 0; z < 2; z++) begin
                for (int i = 0; i < nx[z]; i++) begin
                    if (dst_vld[i] && trk(z, da(i))) begin
                        int t;
                        t = act + 1 + (is_load[i] ? LOAD_LAT : ALU_LAT);
                        if (t > rdy[z][da(i)])
                            rdy[z][da(i)] = t;
                    end
                end
            end
            act++;
        end
    endtask

    task automatic clr();
        slot_vld  = '0;
        src_addr  = '0;
        src_vld   = '0;
        dst_addr  = '0;
        dst_vld   = '0;
        is_load   = '0;
        is_branch = '0;
        ex_hold   = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic put(input int i, input int d, input bit dv,
                       input bit ld, input bit br,
                       input int s, input bit sv);
        slot_vld[i]          = 1'b1;
        dst_addr[i*3 +: 3]   = 3'(d);
        dst_vld[i]           = dv;
        is_load[i]           = ld;
        is_branch[i]         = br;
        src_addr[i*9 +: 3]   = 3'(s);
        src_vld[i*3]         = sv;
    endtask

    function automatic logic [2:0] ra();
        return ($urandom % 3 == 0) ? 3'($urandom) : 3'($urandom % 4);
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        act   = 0;
        for (int z = 0; z < 2; z++) begin
            nx[z] = 0;
            for (int r = 0; r < NREG; r++)
                rdy[z][r] = 0;
        end
        clr();
        rst = 1'b1;
        look();
        check("rst issue", int'(hz0.issue_cnt), 0);
        check("rst pcw", int'(hz0.pc_write), 0);
        tick();
        look();
        tick();
        rst = 1'b0;

        put(0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        put(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        look();
        check("post-rst issue", int'(hz0.issue_cnt), 2);
        check("post-rst pcw", int'(hz0.pc_write), 1);
        check("post-rst bubble", int'(hz0.ctrl_bubble), 0);
        check("post-rst busy", int'(hz0.busy), 0);
        tick();

        clr(); put(0, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 7, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        look();
        check("ld-alu stall", int'(hz0.issue_cnt), 0);
        check("ld-alu bubble", int'(hz0.ctrl_bubble), 1);
        check("ld-alu pcw", int'(hz0.pc_write), 0);
        tick(); look();
        check("ld-alu go", int'(hz0.issue_cnt), 1);
        tick();

        clr(); put(0, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            look();
            check($sformatf("ld-br c%0d", c), int'(hz0.issue_cnt),
                  (c < 2) ? 0 : 1);
            tick();
        end

        clr(); put(0, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1);
        for (int c = 0; c < 2; c++) begin
            look();
            check($sformatf("alu-br c%0d", c), int'(hz0.issue_cnt),
                  (c < 1) ? 0 : 1);
            tick();
        end
        clr(); put(0, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        look();
        check("alu-alu issue", int'(hz0.issue_cnt), 1);
        check("alu-alu bubble", int'(hz0.ctrl_bubble), 0);
        tick();

        clr();
        put(0, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        put(1, 0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        look();
        check("bundle issue", int'(hz0.issue_cnt), 1);
        check("bundle pcw", int'(hz0.pc_write), 0);
        check("bundle ifid", int'(hz0.if_id_write), 0);
        check("bundle bubble", int'(hz0.ctrl_bubble), 0);
        tick();
        clr(); look();
        check("bundle busy2", int'(hz0.busy[2]), 1);
        tick();

        clr(); put(0, 4, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        ex_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            look();
            check($sformatf("hold busy4 c%0d", c), int'(hz0.busy[4]), 1);
            check($sformatf("hold issue c%0d", c), int'(hz0.issue_cnt), 0);
            tick();
        end
        ex_hold = 1'b0;
        look();
        check("hold rel stall", int'(hz0.issue_cnt), 0);
        tick(); look();
        check("hold rel go", int'(hz0.issue_cnt), 1);
        tick();

        clr();
        put(0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        put(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        flush = 1'b1;
        look();
        check("flush issue", int'(hz0.issue_cnt), 0);
        check("flush bubble", int'(hz0.ctrl_bubble), 1);
        tick();

        clr(); put(0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        look();
        check("zr issue", int'(hz1.issue_cnt), 1);
        check("zr busy0", int'(hz1.busy[0]), 0);
        check("r0 tracked", int'(hz0.issue_cnt), 0);
        tick();
        clr(); look(); tick();

        clr();
        put(0, 6, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        put(1, 6, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look();
        check("dbl issue", int'(hz1.issue_cnt), 2);
        tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b0, 6, 1'b1);
        look();
        check("dbl stall", int'(hz1.issue_cnt), 0);
        tick(); look();
        check("dbl go", int'(hz1.issue_cnt), 1);
        tick();

        clr(); put(0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        look(); tick();
        clr(); put(0, 0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        rst = 1'b1;
        look(); tick();
        rst = 1'b0;
        look();
        check("rst mid-stall", int'(hz0.issue_cnt), 1);
        tick();

        for (int n = 0; n < 1500; n++) begin
            slot_vld  = 2'($urandom);
            src_vld   = 6'($urandom & $urandom);
            dst_vld   = 2'($urandom);
            is_load   = 2'($urandom);
            is_branch = 2'($urandom & $urandom);
            for (int k = 0; k < 6; k++)
                src_addr[k*3 +: 3] = ra();
            for (int i = 0; i < 2; i++)
                dst_addr[i*3 +: 3] = ra();
            ex_hold = ($urandom % 8 == 0);
            flush   = ($urandom % 10 == 0);
            rst     = ($urandom % 60 == 0);
            look();
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
